// File: rtl/ins_encode_writer_if.sv
//------------------------------------------------------------------------------
// ins_encode_writer_if
//
// Purpose : bundles the field-set handshake (source -> writer) and the
//           instruction-memory write port (writer -> memory) of
//           ins_encode_writer into one interface.
//
// Signals :
//   in_valid  source has a field set on the bus
//   in_ready  writer can take a field set this cycle
//   in_last   field set is the final one of the session
//   fmt       instruction format (0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal)
//   opcode, funct3, funct7, rd, rs1, rs2, imm32 : instruction fields
//   mem_we    instruction-memory write strobe
//   mem_addr  instruction-memory word address
//   mem_wdata encoded 32-bit instruction word
//
// Modports:
//   master  field source / memory side (drives fields, observes write port)
//   slave   the writer itself
//------------------------------------------------------------------------------
interface ins_encode_writer_if #(
   parameter int ADDR_W = 6
);
   logic              in_valid;
   logic              in_ready;
   logic              in_last;
   logic [2:0]        fmt;
   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [31:0]       imm32;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output in_valid,
      output in_last,
      output fmt,
      output opcode,
      output funct3,
      output funct7,
      output rd,
      output rs1,
      output rs2,
      output imm32,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

   modport slave (
      input  in_valid,
      input  in_last,
      input  fmt,
      input  opcode,
      input  funct3,
      input  funct7,
      input  rd,
      input  rs1,
      input  rs2,
      input  imm32,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );
endinterface

// File: rtl/ins_encode_writer.sv
//------------------------------------------------------------------------------
// ins_encode_writer
//
// Purpose : accepts RISC-V style instruction field sets over a valid/ready
//           handshake, packs each into a 32-bit instruction word according
//           to its format (R/I/S/B/U/J) and writes the words to consecutive
//           addresses of an instruction memory, starting at base_addr.
//           A session ends after the field set flagged in_last, or when
//           every word of the memory has been written once.
//
// Ports   :
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse, opens a session (ignored while busy)
//   base_addr  first word address written in the session
//   bus        ins_encode_writer_if.slave (field handshake + memory write)
//   busy       session in progress (ACCEPT, WRITE or DONE)
//   done       one-cycle pulse at the end of a session
//   full       last session filled the whole memory (held until next start)
//   err        an illegal field set was seen (held until next start)
//   count      words written in the current/last session (ADDR_W+1 bits)
//
// Configuration:
//   INS_ENCODE_FMT_CHECK_EN  when defined, a field set with fmt 6/7 or an
//                            opcode whose two low bits are not 2'b11 is
//                            dropped and flags err. When undefined, err
//                            stays 0 and illegal formats pack as R-type.
//
// All outputs are registered; the handshake/strobe outputs are decoded from
// the next state so they line up exactly with the state they belong to.
//------------------------------------------------------------------------------
module ins_encode_writer #(
   parameter int ADDR_W = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   ins_encode_writer_if.slave   bus,
   output logic                 busy,
   output logic                 done,
   output logic                 full,
   output logic                 err,
   output logic [ADDR_W:0]      count
);

   // Instruction format codes.
   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   // Number of words in the target memory, as a count value.
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_WRITE  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   //---------------------------------------------------------------------------
   // Instruction packing. Immediate bits that a format does not carry are
   // dropped; B and J never store imm[0] since their targets are 2-byte
   // aligned.
   //---------------------------------------------------------------------------
   function automatic logic [31:0] encode_word(
      input logic [2:0]  fmt,
      input logic [6:0]  opcode,
      input logic [2:0]  funct3,
      input logic [6:0]  funct7,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [31:0] imm
   );
      logic [31:0] word_v;
      case (fmt)
         FMT_R:   word_v = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I:   word_v = {imm[11:0], rs1, funct3, rd, opcode};
         FMT_S:   word_v = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B:   word_v = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], opcode};
         FMT_U:   word_v = {imm[31:12], rd, opcode};
         FMT_J:   word_v = {imm[20], imm[10:1], imm[11], imm[19:12],
                            rd, opcode};
         // fmt 6/7: packed as R so an unchecked build still writes something
         // deterministic.
         default: word_v = {funct7, rs2, rs1, funct3, rd, opcode};
      endcase
      return word_v;
   endfunction

`ifdef INS_ENCODE_FMT_CHECK_EN
   // A field set is legal when its format is defined and the opcode is a
   // 32-bit encoding (low two bits 2'b11).
   function automatic logic field_set_legal(
      input logic [2:0] fmt,
      input logic [6:0] opcode
   );
      return (fmt <= FMT_J) && (opcode[1:0] == 2'b11);
   endfunction
`endif

   state_t              state_r;
   state_t              state_s;

   logic                in_ready_r;
   logic                busy_r;
   logic                done_r;
   logic                mem_we_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [31:0]         mem_wdata_r;

   logic [ADDR_W-1:0]   addr_r;
   logic [ADDR_W:0]     count_r;
   logic                full_r;
   logic                err_r;
   logic                last_r;

   logic                xfer_s;
   logic                legal_s;
   logic [31:0]         encoded_s;
   logic [ADDR_W:0]     count_inc_s;
   logic                mem_filled_s;

   // A field set moves only while the writer sits in ACCEPT; in_valid in any
   // other state is left on the bus for later.
   assign xfer_s = (state_r == ST_ACCEPT) && bus.in_valid;

`ifdef INS_ENCODE_FMT_CHECK_EN
   assign legal_s = field_set_legal(bus.fmt, bus.opcode);
`else
   assign legal_s = 1'b1;
`endif

   assign count_inc_s  = count_r + {{ADDR_W{1'b0}}, 1'b1};
   // The word being written now is the one that fills the memory.
   assign mem_filled_s = (count_inc_s == DEPTH);

   // Pack the field set currently presented on the bus.
   always_comb begin
      encoded_s = 32'h0000_0000;
      encoded_s = encode_word(bus.fmt, bus.opcode, bus.funct3, bus.funct7,
                              bus.rd, bus.rs1, bus.rs2, bus.imm32);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_ACCEPT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ACCEPT: begin
            if (xfer_s) begin
               if (legal_s) begin
                  state_s = ST_WRITE;
               end else if (bus.in_last) begin
                  // Dropped field set still closes the session.
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_ACCEPT;
               end
            end else begin
               state_s = ST_ACCEPT;
            end
         end
         ST_WRITE: begin
            if (last_r || mem_filled_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_ACCEPT;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Handshake and strobe outputs, registered from the next state so each is
   // high for exactly the cycles spent in its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         mem_we_r   <= 1'b0;
      end else begin
         in_ready_r <= (state_s == ST_ACCEPT);
         busy_r     <= (state_s != ST_IDLE);
         done_r     <= (state_s == ST_DONE);
         mem_we_r   <= (state_s == ST_WRITE);
      end
   end

   // Write port address/data: captured on an accepted legal transfer and
   // held steady through the following WRITE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= 32'h0000_0000;
         last_r      <= 1'b0;
      end else if (xfer_s && legal_s) begin
         mem_addr_r  <= addr_r;
         mem_wdata_r <= encoded_s;
         last_r      <= bus.in_last;
      end else begin
         mem_addr_r  <= mem_addr_r;
         mem_wdata_r <= mem_wdata_r;
         last_r      <= last_r;
      end
   end

   // Session bookkeeping: write pointer, word count and sticky status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r  <= {ADDR_W{1'b0}};
         count_r <= {(ADDR_W + 1){1'b0}};
         full_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  addr_r  <= base_addr;
                  count_r <= {(ADDR_W + 1){1'b0}};
                  full_r  <= 1'b0;
                  err_r   <= 1'b0;
               end
            end
            ST_ACCEPT: begin
               // Dropped field sets leave addr/count untouched.
               if (xfer_s && !legal_s) begin
                  err_r <= 1'b1;
               end
            end
            ST_WRITE: begin
               // Pointer wraps naturally at the top of the memory.
               addr_r  <= addr_r + ADDR_W'(1'b1);
               count_r <= count_inc_s;
               if (mem_filled_s) begin
                  full_r <= 1'b1;
               end
            end
            ST_DONE: begin
               addr_r <= addr_r;
            end
            default: begin
               addr_r <= addr_r;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;

   assign busy  = busy_r;
   assign done  = done_r;
   assign full  = full_r;
   assign err   = err_r;
   assign count = count_r;

endmodule

// File: tb/tb_ins_encode_writer.sv
//------------------------------------------------------------------------------
// tb_ins_encode_writer
//
// Directed and randomized load sessions for ins_encode_writer (ADDR_W=6).
// Expected memory contents come from an arithmetic model of the instruction
// formats (bit-field shifts on plain integers) and a session model that
// tracks address, count and error flags.
//------------------------------------------------------------------------------
module tb_ins_encode_writer;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 64;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } fields_t;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              busy;
   logic              done;
   logic              full;
   logic              err;
   logic [ADDR_W:0]   count;

   ins_encode_writer_if #(.ADDR_W(ADDR_W)) bus ();

   ins_encode_writer #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .full      (full),
      .err       (err),
      .count     (count)
   );

   int n_checks = 0;
   int n_errors = 0;

   fields_t     stim_q[$];
   logic [37:0] wr_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture every memory write strobe seen mid-cycle.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.mem_we === 1'b1) begin
         wr_q.push_back({bus.mem_addr, bus.mem_wdata});
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference packing from bit positions of each format.
   function automatic logic [31:0] ref_encode(input fields_t f);
      int unsigned op, f3, f7, rd, rs1, rs2, imm, w;
      op = f.op; f3 = f.f3; f7 = f.f7; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2; imm = f.imm;
      case (f.fmt)
         3'd1: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
         3'd2: w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | ((imm & 32'h1F) << 7) | op;
         3'd3: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                   | (((imm >> 11) & 32'h1) << 7) | op;
         3'd4: w = (imm & 32'hFFFF_F000) | (rd << 7) | op;
         3'd5: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (rd << 7) | op;
         default: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      endcase
      return w;
   endfunction

   function automatic bit ref_legal(input fields_t f);
`ifdef INS_ENCODE_FMT_CHECK_EN
      return (int'(f.fmt) < 6) && ((int'(f.op) % 4) == 3);
`else
      return (f.fmt === f.fmt);
`endif
   endfunction

   function automatic fields_t mk(input int fmt, input int op, input int f3, input int f7,
                                  input int rd, input int rs1, input int rs2, input int imm);
      fields_t f;
      f.fmt = 3'(fmt); f.op = 7'(op); f.f3 = 3'(f3); f.f7 = 7'(f7);
      f.rd = 5'(rd); f.rs1 = 5'(rs1); f.rs2 = 5'(rs2); f.imm = 32'(imm);
      return f;
   endfunction

   function automatic fields_t rand_fields(input bit allow_illegal);
      fields_t f;
      f.fmt = allow_illegal ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
      f.op  = 7'($urandom);
      if (!allow_illegal || $urandom_range(0, 3) != 0) f.op[1:0] = 2'b11;
      f.f3  = 3'($urandom);
      f.f7  = 7'($urandom);
      f.rd  = 5'($urandom);
      f.rs1 = 5'($urandom);
      f.rs2 = 5'($urandom);
      f.imm = $urandom;
      return f;
   endfunction

   task automatic drive_idle_fields();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.fmt      = 3'($urandom);
      bus.opcode   = 7'($urandom);
      bus.funct3   = 3'($urandom);
      bus.funct7   = 7'($urandom);
      bus.rd       = 5'($urandom);
      bus.rs1      = 5'($urandom);
      bus.rs2      = 5'($urandom);
      bus.imm32    = $urandom;
   endtask

   // Present one field set and hold it until the writer takes it.
   task automatic send(input fields_t f, input bit lst);
      int waits = 0;
      bus.fmt = f.fmt; bus.opcode = f.op; bus.funct3 = f.f3; bus.funct7 = f.f7;
      bus.rd = f.rd; bus.rs1 = f.rs1; bus.rs2 = f.rs2; bus.imm32 = f.imm;
      bus.in_last  = lst;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && waits < 16) begin
         @(negedge clk);
         waits++;
      end
      check("in_ready_within_bound", 64'(waits < 16), 64'd1);
      @(negedge clk);
      drive_idle_fields();
   endtask

   // Run one session from stim_q and compare it against the session model.
   task automatic run_session(input logic [ADDR_W-1:0] base, input bit last_on_final,
                              input bit poke_start);
      int unsigned exp_addr, exp_cnt;
      bit          exp_err, ended, lst;
      logic [37:0] exp_q[$];
      int          waits;
      exp_addr = base; exp_cnt = 0; exp_err = 0; ended = 0;
      wr_q.delete();
      start = 1'b1; base_addr = base;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
      check("count_cleared", 64'(count), 64'd0);
      for (int i = 0; i < stim_q.size() && !ended; i++) begin
         lst = last_on_final && (i == stim_q.size() - 1);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         if (poke_start && i == 1) begin
            start = 1'b1; base_addr = base ^ 6'h2A;
            @(negedge clk);
            start = 1'b0; base_addr = base;
         end
         send(stim_q[i], lst);
         if (ref_legal(stim_q[i])) begin
            exp_q.push_back({6'(exp_addr), ref_encode(stim_q[i])});
            exp_addr = (exp_addr + 1) % DEPTH;
            exp_cnt++;
         end else begin
            exp_err = 1'b1;
         end
         if (lst || exp_cnt == DEPTH) ended = 1'b1;
      end
      waits = 0;
      while (done !== 1'b1 && waits < 8) begin
         @(negedge clk);
         waits++;
      end
      check("done_pulse_seen", 64'(done), 64'd1);
      check("busy_in_done", 64'(busy), 64'd1);
      check("count_at_done", 64'(count), 64'(exp_cnt));
      check("full_at_done", 64'(full), 64'(exp_cnt == DEPTH));
      check("err_at_done", 64'(err), 64'(exp_err));
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      check("busy_after_done", 64'(busy), 64'd0);
      check("full_held", 64'(full), 64'(exp_cnt == DEPTH));
      check("err_held", 64'(err), 64'(exp_err));
      check("write_count", 64'(wr_q.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
         check("write_addr_data", 64'(wr_q[k]), 64'(exp_q[k]));
      end
   endtask

   task automatic check_word(input int idx, input int addr, input logic [31:0] data);
      check("word_present", 64'(wr_q.size() > idx), 64'd1);
      if (wr_q.size() > idx) begin
         check("word_addr", 64'(wr_q[idx][37:32]), 64'(addr));
         check("word_data", 64'(wr_q[idx][31:0]), 64'(data));
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0;
      drive_idle_fields();
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_full", 64'(full), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_mem_we", 64'(bus.mem_we), 64'd0);
      check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_in_ready", 64'(bus.in_ready), 64'd0);

      // Single I-type word
      stim_q.delete();
      stim_q.push_back(mk(1, 7'b0010011, 0, 0, 1, 0, 0, 5));
      run_session(6'd0, 1'b1, 1'b0);
      check_word(0, 0, 32'h0050_0093);

      // R then S
      stim_q.delete();
      stim_q.push_back(mk(0, 7'b0110011, 0, 0, 3, 1, 2, 0));
      stim_q.push_back(mk(2, 7'b0100011, 2, 0, 0, 1, 2, 8));
      run_session(6'd0, 1'b1, 1'b0);
      check_word(0, 0, 32'h0020_81B3);
      check_word(1, 1, 32'h0020_A423);

      // J then U
      stim_q.delete();
      stim_q.push_back(mk(5, 7'b1101111, 0, 0, 1, 0, 0, 8));
      stim_q.push_back(mk(4, 7'b0110111, 0, 0, 5, 0, 0, 32'h1234_5000));
      run_session(6'd10, 1'b1, 1'b0);
      check_word(0, 10, 32'h0080_00EF);
      check_word(1, 11, 32'h1234_52B7);

      // Address wrap from the top word
      stim_q.delete();
      stim_q.push_back(rand_fields(1'b0));
      stim_q.push_back(rand_fields(1'b0));
      run_session(6'd63, 1'b1, 1'b0);
      check_word(0, 63, ref_encode(stim_q[0]));
      check_word(1, 0, ref_encode(stim_q[1]));

      // Fill the whole memory without in_last
      stim_q.delete();
      for (int i = 0; i < DEPTH; i++) stim_q.push_back(rand_fields(1'b0));
      run_session(6'd0, 1'b0, 1'b0);

      // Illegal format 7 closing the session, then fmt 6 followed by a legal word
      stim_q.delete();
      stim_q.push_back(mk(7, 7'b0110011, 1, 5, 4, 3, 2, 0));
      run_session(6'd5, 1'b1, 1'b0);
      stim_q.delete();
      stim_q.push_back(mk(6, 7'b0010011, 1, 5, 4, 3, 2, 9));
      stim_q.push_back(mk(1, 7'b0010011, 0, 0, 2, 2, 0, 32'hFFFF_FFFF));
      run_session(6'd7, 1'b1, 1'b0);

      // Randomized sessions, some with a start pulse while busy
      for (int s = 0; s < 8; s++) begin
         int n;
         n = $urandom_range(1, 8);
         stim_q.delete();
         for (int i = 0; i < n; i++) stim_q.push_back(rand_fields(1'b1));
         run_session(6'($urandom), 1'b1, 1'(s % 2));
      end

      // Reset asserted during WRITE
      stim_q.delete();
      start = 1'b1; base_addr = 6'd20;
      @(negedge clk);
      start = 1'b0;
      send(rand_fields(1'b0), 1'b0);
      check("we_before_reset", 64'(bus.mem_we), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_mem_we", 64'(bus.mem_we), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_count", 64'(count), 64'd0);
      check("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wr_q.delete();
      repeat (4) @(negedge clk);
      check("no_write_after_abort", 64'(wr_q.size()), 64'd0);
      check("idle_after_abort", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
